// File: rtl/batch_mul_pipe.sv
// Pipelined signed x unsigned multiplier with valid/ready backpressure and an
// optional burst multiply-accumulate in the final stage.
module batch_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int DIN0_WIDTH = 25,
  parameter int DIN1_WIDTH = 9,
  parameter int DOUT_WIDTH = 34,
  parameter int ACC_EN     = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_last
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  function automatic logic signed [PW-1:0] mul_full(input logic signed [DIN0_WIDTH-1:0] a,
                                                    input logic [DIN1_WIDTH-1:0] b);
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    a_ext = PW'(a);
    b_ext = PW'($signed({1'b0, b}));
    return a_ext * b_ext;
  endfunction

  // Sign-extends or truncates (keeping LSBs) the full product to the output width.
  function automatic logic signed [DOUT_WIDTH-1:0] fit_out(input logic signed [PW-1:0] p);
    return DOUT_WIDTH'(p);
  endfunction

  logic                         ce;
  logic signed [DOUT_WIDTH-1:0] prod;
  logic                         feed_vld;
  logic                         feed_last;
  logic signed [DOUT_WIDTH-1:0] feed_dat;

  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q,  out_last_d;
  logic signed [DOUT_WIDTH-1:0] dout_q,      dout_d;
  logic signed [DOUT_WIDTH-1:0] acc_q,       acc_d;

  assign ce       = !out_valid_q || out_ready;
  assign in_ready = ce;
  assign prod     = fit_out(mul_full($signed(din0), din1));

  generate
    if (NUM_STAGE > 1) begin : g_pre
      logic                         vld_q  [NUM_STAGE-1];
      logic                         last_q [NUM_STAGE-1];
      logic signed [DOUT_WIDTH-1:0] dat_q  [NUM_STAGE-1];

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          for (int i = 0; i < NUM_STAGE-1; i++) vld_q[i] <= 1'b0;
        end else if (ce) begin
          vld_q[0] <= in_valid;
          for (int i = 1; i < NUM_STAGE-1; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      // Data only moves with a valid beat so inputs are never sampled unaccepted.
      always_ff @(posedge ap_clk) begin
        if (ce) begin
          if (in_valid) begin
            dat_q[0]  <= prod;
            last_q[0] <= in_last;
          end
          for (int i = 1; i < NUM_STAGE-1; i++) begin
            if (vld_q[i-1]) begin
              dat_q[i]  <= dat_q[i-1];
              last_q[i] <= last_q[i-1];
            end
          end
        end
      end

      assign feed_vld  = vld_q[NUM_STAGE-2];
      assign feed_last = last_q[NUM_STAGE-2];
      assign feed_dat  = dat_q[NUM_STAGE-2];
    end else begin : g_direct
      assign feed_vld  = in_valid;
      assign feed_last = in_last;
      assign feed_dat  = prod;
    end
  endgenerate

  // Final stage: plain output register, or accumulator that emits on last.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    dout_d      = dout_q;
    acc_d       = acc_q;
    if (ce) begin
      if (ACC_EN == 0) begin
        out_valid_d = feed_vld;
        if (feed_vld) begin
          dout_d     = feed_dat;
          out_last_d = feed_last;
        end
      end else begin
        out_valid_d = feed_vld && feed_last;
        if (feed_vld) begin
          if (feed_last) begin
            dout_d     = acc_q + feed_dat;
            out_last_d = 1'b1;
            acc_d      = '0;
          end else begin
            acc_d = acc_q + feed_dat;
          end
        end
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      dout_q      <= '0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      dout_q      <= dout_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign dout      = dout_q;

endmodule
